// File: rtl/joy_scan_controller.sv
// Serial joystick scanner: parallel-loads two external shift registers, clocks
// them out one bit per tick pair and publishes both pads together per scan.
module joy_scan_controller #(
  parameter int BITS       = 12,
  parameter int SCAN_GAP   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk_peripheral,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            scan_enable,
  input  logic            joy_data,
  output logic            joy_load_n,
  output logic            joy_clk,
  output logic            joy_sel,
  output logic [BITS-1:0] joy_left,
  output logic [BITS-1:0] joy_right,
  output logic            joy_valid,
  output logic            joy_busy
);

  localparam int            BW       = $clog2(BITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [7:0]    GAP_LAST = 8'(SCAN_GAP);

  typedef enum logic [1:0] {IDLE, LOAD, S_LO, S_HI} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      gap_reg, gap_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic            sel_reg, sel_next;
  logic [BITS-1:0] shadow_left_reg, shadow_left_next;
  logic [BITS-1:0] shadow_right_reg, shadow_right_next;
  logic [BITS-1:0] left_reg, left_next;
  logic [BITS-1:0] right_reg, right_next;
  logic            valid_reg, valid_next;
  logic            sample;

  // Captured bits are normalised so that 1 always means pressed.
  assign sample = joy_data ^ ACTIVE_LOW;

  always_ff @(posedge clk_peripheral or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      gap_reg          <= '0;
      bit_reg          <= '0;
      sel_reg          <= 1'b0;
      shadow_left_reg  <= '0;
      shadow_right_reg <= '0;
      left_reg         <= '0;
      right_reg        <= '0;
      valid_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      gap_reg          <= gap_next;
      bit_reg          <= bit_next;
      sel_reg          <= sel_next;
      shadow_left_reg  <= shadow_left_next;
      shadow_right_reg <= shadow_right_next;
      left_reg         <= left_next;
      right_reg        <= right_next;
      valid_reg        <= valid_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    gap_next          = gap_reg;
    bit_next          = bit_reg;
    sel_next          = sel_reg;
    shadow_left_next  = shadow_left_reg;
    shadow_right_next = shadow_right_reg;
    left_next         = left_reg;
    right_next        = right_reg;
    valid_next        = 1'b0;
    if (clk_en) begin
      unique case (state_reg)
        IDLE: begin
          if (scan_enable) begin
            if (gap_reg + 8'd1 == GAP_LAST) begin
              gap_next   = '0;
              sel_next   = 1'b0;
              state_next = LOAD;
            end else begin
              gap_next = gap_reg + 8'd1;
            end
          end
        end
        LOAD: begin
          bit_next   = '0;
          state_next = S_LO;
        end
        S_LO: begin
          if (sel_reg) shadow_right_next = {shadow_right_reg[BITS-2:0], sample};
          else         shadow_left_next  = {shadow_left_reg[BITS-2:0], sample};
          bit_next   = bit_reg + BIT_ONE;
          state_next = S_HI;
        end
        S_HI: begin
          if (bit_reg != BIT_LAST) begin
            state_next = S_LO;
          end else if (!sel_reg) begin
            sel_next   = 1'b1;
            state_next = LOAD;
          end else begin
            // Both pads are published at once so a half-finished scan is never visible.
            left_next  = shadow_left_reg;
            right_next = shadow_right_reg;
            valid_next = 1'b1;
            sel_next   = 1'b0;
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  assign joy_load_n = (state_reg != LOAD);
  assign joy_clk    = (state_reg == S_HI);
  assign joy_busy   = (state_reg != IDLE);
  assign joy_sel    = sel_reg;
  assign joy_left   = left_reg;
  assign joy_right  = right_reg;
  assign joy_valid  = valid_reg;

endmodule

// File: tb/tb_joy_scan_controller.sv
// Bench for joy_scan_controller: two modelled 74HC165 pads, table vectors,
// directed corner sequences and a tick-schedule reference model.
module tb_joy_scan_controller;
  localparam int BITS = 12;
  localparam int SCAN = 54;

  logic clk_peripheral = 1'b0;
  logic rst_n = 1'b0, clk_en = 1'b0, scan_enable = 1'b0;
  logic joy_data, joy_load_n, joy_clk, joy_sel, joy_valid, joy_busy;
  logic [BITS-1:0] joy_left, joy_right;
  int checks = 0, errors = 0;

  joy_scan_controller #(.BITS(BITS), .SCAN_GAP(4), .ACTIVE_LOW(1'b1)) dut (
    .clk_peripheral(clk_peripheral), .rst_n(rst_n), .clk_en(clk_en),
    .scan_enable(scan_enable), .joy_data(joy_data), .joy_load_n(joy_load_n),
    .joy_clk(joy_clk), .joy_sel(joy_sel), .joy_left(joy_left),
    .joy_right(joy_right), .joy_valid(joy_valid), .joy_busy(joy_busy));

  always #5 clk_peripheral = ~clk_peripheral;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s: %h ok", name, act);
    end
  endtask

  // clk_en pacing: fixed period or random
  int tick_period = 128, tick_phase = 0;
  bit ticks_on = 0, rand_ticks = 0;
  always @(negedge clk_peripheral) begin
    if (!ticks_on) begin
      clk_en = 1'b0; tick_phase = 0;
    end else if (rand_ticks) begin
      clk_en = ($urandom_range(0, 1) == 1);
    end else if (tick_phase >= tick_period - 1) begin
      clk_en = 1'b1; tick_phase = 0;
    end else begin
      clk_en = 1'b0; tick_phase++;
    end
  end

  // Two 74HC165 pads: load while load_n low, shift on rising joy_clk
  logic [BITS-1:0] pad_l = '1, pad_r = '1, sr_l = '1, sr_r = '1;
  logic clk_d = 1'b0;
  always @(posedge clk_peripheral) begin
    clk_d <= joy_clk;
    if (!joy_load_n) begin
      sr_l <= pad_l; sr_r <= pad_r;
    end else if (joy_clk && !clk_d) begin
      sr_l <= sr_l << 1; sr_r <= sr_r << 1;
    end
  end
  assign joy_data = joy_sel ? sr_r[BITS-1] : sr_l[BITS-1];

  // Reference model: with scan_enable held, each scan is a fixed 54-tick schedule.
  int mt;
  bit m_pulse;
  logic [BITS-1:0] snap_l, snap_r, pub_l, pub_r;
  always @(posedge clk_peripheral or negedge rst_n) begin
    if (!rst_n) begin
      mt = 0; m_pulse = 0; snap_l = '0; snap_r = '0; pub_l = '0; pub_r = '0;
    end else begin
      m_pulse = 0;
      if (clk_en) begin
        mt++;
        if (mt % SCAN == 5)  snap_l = pad_l;
        if (mt % SCAN == 30) snap_r = pad_r;
        if (mt % SCAN == 0) begin
          pub_l = ~snap_l; pub_r = ~snap_r; m_pulse = 1;
        end
      end
    end
  end

  bit model_on = 0;
  int m;
  always @(negedge clk_peripheral) begin
    if (model_on && rst_n) begin
      m = mt % SCAN;
      chk("rnd_valid", 32'(joy_valid), 32'(m_pulse));
      chk("rnd_left", 32'(joy_left), 32'(pub_l));
      chk("rnd_right", 32'(joy_right), 32'(pub_r));
      chk("rnd_load_n", 32'(joy_load_n), 32'(!(m == 4 || m == 29)));
      chk("rnd_clk", 32'(joy_clk),
          32'((m >= 6 && m <= 28 && m % 2 == 0) || (m >= 31 && m % 2 == 1)));
      chk("rnd_sel", 32'(joy_sel), 32'(m >= 29));
      chk("rnd_busy", 32'(joy_busy), 32'(m >= 4));
    end
  end

  // Load/clock sequencing monitor at 128-cycle pacing
  bit mon_on = 0, seen_load = 0;
  int rises = 0, low_len = 0;
  logic pl_n = 1'b1, pclk = 1'b0, psel = 1'b0;
  always @(negedge clk_peripheral) begin
    if (mon_on) begin
      if (joy_clk && !pclk) rises++;
      if (!joy_load_n) begin
        low_len++;
        if (pl_n) begin
          if (seen_load) chk("clk_rises_between_loads", 32'(rises), 32'd12);
          seen_load = 1; rises = 0;
        end
      end else begin
        if (!pl_n) chk("load_n_low_cycles", 32'(low_len), 32'd128);
        low_len = 0;
      end
      if (joy_sel != psel)
        chk("sel_toggle_at_load_edge", 32'(psel ? !joy_busy : !joy_load_n), 32'd1);
    end
    pl_n = joy_load_n; pclk = joy_clk; psel = joy_sel;
  end

  task automatic wait_valid(input int max_cycles);
    bit ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_peripheral);
      if (joy_valid) begin ok = 1; break; end
    end
    chk("valid_seen", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [BITS-1:0] pl, pr, el, er;
  } vec_t;

  initial begin
    vec_t vecs [6];
    bit ok;
    int n_load, n_busy, n_valid;
    vecs[0] = '{12'h5A3, 12'hC0F, 12'hA5C, 12'h3F0};
    vecs[1] = '{12'hFFF, 12'h000, 12'h000, 12'hFFF};
    vecs[2] = '{12'h7FE, 12'h801, 12'h801, 12'h7FE};
    vecs[3] = '{12'hAAA, 12'h555, 12'h555, 12'hAAA};
    vecs[4] = '{12'h123, 12'hEDC, 12'hEDC, 12'h123};
    vecs[5] = '{12'h0F0, 12'hF0F, 12'hF0F, 12'h0F0};

    repeat (4) @(negedge clk_peripheral);
    chk("rst_load_n", 32'(joy_load_n), 32'd1);
    chk("rst_clk", 32'(joy_clk), 32'd0);
    chk("rst_sel", 32'(joy_sel), 32'd0);
    chk("rst_left", 32'(joy_left), 32'd0);
    chk("rst_right", 32'(joy_right), 32'd0);
    chk("rst_valid", 32'(joy_valid), 32'd0);
    chk("rst_busy", 32'(joy_busy), 32'd0);

    // Released pads at the 128-cycle rate: nothing pressed after 54 ticks
    scan_enable = 1; tick_period = 128; ticks_on = 1; mon_on = 1; rst_n = 1;
    wait_valid(60 * 128);
    chk("t1_ticks_to_valid", 32'(mt), 32'd54);
    chk("t1_left", 32'(joy_left), 32'd0);
    chk("t1_right", 32'(joy_right), 32'd0);
    wait_valid(60 * 128);
    chk("t1_second_scan_ticks", 32'(mt), 32'd108);
    mon_on = 0;

    tick_period = 3;
    for (int i = 0; i < 6; i++) begin
      pad_l = vecs[i].pl; pad_r = vecs[i].pr;
      wait_valid(400);
      chk("vec_left", 32'(joy_left), 32'(vecs[i].el));
      chk("vec_right", 32'(joy_right), 32'(vecs[i].er));
    end

    // Pattern change during the right-port shift must not leak in
    pad_l = 12'h5A3; pad_r = 12'hC0F;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_peripheral);
      if (joy_sel && joy_clk) begin ok = 1; break; end
    end
    chk("t4_reached_right_shift", 32'(ok), 32'd1);
    pad_l = 12'h000; pad_r = 12'h000;
    chk("t4_hold_left", 32'(joy_left), 32'h0F0 ^ 32'hFFF);
    chk("t4_hold_right", 32'(joy_right), 32'h0F0);
    wait_valid(400);
    chk("t4_snapshot_left", 32'(joy_left), 32'hA5C);
    chk("t4_snapshot_right", 32'(joy_right), 32'h3F0);
    wait_valid(400);
    chk("t4_next_left", 32'(joy_left), 32'hFFF);
    chk("t4_next_right", 32'(joy_right), 32'hFFF);

    // scan_enable dropped during left-port S_LO: scan finishes, then halts
    pad_l = 12'h00F; pad_r = 12'hF00;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_peripheral);
      if (joy_busy && !joy_sel && joy_load_n && !joy_clk) begin ok = 1; break; end
    end
    chk("t5_reached_left_lo", 32'(ok), 32'd1);
    scan_enable = 0;
    wait_valid(400);
    chk("t5_left", 32'(joy_left), 32'hFF0);
    chk("t5_right", 32'(joy_right), 32'h0FF);
    n_load = 0; n_busy = 0; n_valid = 0;
    repeat (300) begin
      @(negedge clk_peripheral);
      if (!joy_load_n) n_load++;
      if (joy_busy) n_busy++;
      if (joy_valid) n_valid++;
    end
    chk("t5_no_loads", 32'(n_load), 32'd0);
    chk("t5_not_busy", 32'(n_busy), 32'd0);
    chk("t5_no_valid", 32'(n_valid), 32'd0);

    // Reset during the right-port shift
    scan_enable = 1;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_peripheral);
      if (joy_sel && joy_clk) begin ok = 1; break; end
    end
    chk("t6_reached_right_shift", 32'(ok), 32'd1);
    rst_n = 0;
    #1;
    chk("t6_load_n", 32'(joy_load_n), 32'd1);
    chk("t6_clk", 32'(joy_clk), 32'd0);
    chk("t6_sel", 32'(joy_sel), 32'd0);
    chk("t6_left", 32'(joy_left), 32'd0);
    chk("t6_right", 32'(joy_right), 32'd0);
    chk("t6_busy", 32'(joy_busy), 32'd0);
    repeat (2) @(negedge clk_peripheral);
    rst_n = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_peripheral);
      if (!joy_load_n) begin ok = 1; break; end
    end
    chk("t6_load_seen", 32'(ok), 32'd1);
    chk("t6_ticks_to_first_load", 32'(mt), 32'd4);

    // Random pacing and random pad activity against the schedule model
    rst_n = 0;
    repeat (2) @(negedge clk_peripheral);
    rand_ticks = 1; rst_n = 1; model_on = 1;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk_peripheral);
      if ($urandom_range(0, 39) == 0) pad_l = 12'($urandom);
      if ($urandom_range(0, 39) == 0) pad_r = 12'($urandom);
    end
    model_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
